// File: rtl/lfsr_hex_display.sv
// Parametrised Fibonacci LFSR with seed load, free-run/single-step modes and a registered
// hex seven-segment driver. Define LFSR_PERIOD_CNT_EN to add the period measurement outputs.
module lfsr_hex_display #(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'h1D,
    parameter logic [WIDTH-1:0] SEED   = 8'h01,
    localparam int unsigned     DIGITS = (WIDTH + 3) / 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_mode,
    input  logic                  i_step_btn,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_seed_in,
    output logic [WIDTH-1:0]      o_random,
    output logic                  o_step_pulse,
    output logic [7*DIGITS-1:0]   o_seg
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [31:0]           o_period,
    output logic                  o_period_valid
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StSingle} state_e;

    state_e              r_state;
    logic [WIDTH-1:0]    r_random;
    logic                r_btn_q;
    logic                r_step_pulse;
    logic [7*DIGITS-1:0] r_seg;

    logic                w_fb;
    logic [WIDTH-1:0]    w_next;
    logic [WIDTH-1:0]    w_load_val;
    logic                w_lockup;
    logic                w_advance;
    logic                w_take;
    logic [4*DIGITS-1:0] w_padded;
    logic [7*DIGITS-1:0] w_seg;

    function automatic logic [6:0] hex7(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'h0:    v = 7'b1000000;
            4'h1:    v = 7'b1111001;
            4'h2:    v = 7'b0100100;
            4'h3:    v = 7'b0110000;
            4'h4:    v = 7'b0011001;
            4'h5:    v = 7'b0010010;
            4'h6:    v = 7'b0000010;
            4'h7:    v = 7'b1111000;
            4'h8:    v = 7'b0000000;
            4'h9:    v = 7'b0010000;
            4'hA:    v = 7'b0001000;
            4'hB:    v = 7'b0000011;
            4'hC:    v = 7'b1000110;
            4'hD:    v = 7'b0100001;
            4'hE:    v = 7'b0000110;
            default: v = 7'b0001110;
        endcase
        return v;
    endfunction

    assign w_fb       = ^(r_random & TAPS);
    assign w_next     = {w_fb, r_random[WIDTH-1:1]};
    assign w_load_val = (i_seed_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : i_seed_in;
    assign w_lockup   = (r_random == '0);
    // Step decision uses the state registered last cycle, not the live en/mode.
    assign w_advance  = (r_state == StRun) ||
                        ((r_state == StSingle) && i_step_btn && !r_btn_q);
    assign w_take     = w_advance && !i_load && !w_lockup;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_random     <= SEED;
            r_btn_q      <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_btn_q      <= i_step_btn;
            r_state      <= !i_en ? StIdle : (i_mode ? StSingle : StRun);
            r_step_pulse <= w_take;
            if (i_load) begin
                r_random <= w_load_val;
            end else if (w_lockup) begin
                r_random <= {{(WIDTH-1){1'b0}}, 1'b1};
            end else if (w_advance) begin
                r_random <= w_next;
            end
        end
    end

    always_comb begin
        w_padded              = '0;
        w_padded[WIDTH-1:0]   = r_random;
        w_seg                 = '1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            w_seg[7*d +: 7] = hex7(w_padded[4*d +: 4]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg <= '1;
        end else begin
            r_seg <= w_seg;
        end
    end

    assign o_random     = r_random;
    assign o_step_pulse = r_step_pulse;
    assign o_seg        = r_seg;

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] r_seed_ref;
    logic [31:0]      r_cnt;
    logic [31:0]      r_period;
    logic             r_period_valid;

    // Capture when the state is back at the seed; a step taken that same cycle counts as 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seed_ref     <= SEED;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else if (i_load) begin
            r_seed_ref     <= w_load_val;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else if ((r_random == r_seed_ref) && (r_cnt != '0)) begin
            r_period       <= r_cnt;
            r_period_valid <= 1'b1;
            r_cnt          <= w_take ? 32'd1 : 32'd0;
        end else if (w_take) begin
            r_cnt          <= r_cnt + 32'd1;
        end
    end

    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
`endif

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Bench for lfsr_hex_display: a default 8-bit instance and a 10-bit instance share stimulus and
// are checked every cycle against an arithmetic model, plus directed literal expectations.
module tb_lfsr_hex_display;

    logic       clk = 1'b0;
    logic       rst, en, mode, btn, load;
    logic [9:0] seed_in;

    logic [7:0]  rand0;
    logic        pulse0;
    logic [13:0] seg0;
    logic [9:0]  rand1;
    logic        pulse1;
    logic [20:0] seg1;
`ifdef LFSR_PERIOD_CNT_EN
    logic [31:0] period0, period1;
    logic        pvalid0, pvalid1;
`endif

    always #5 clk = ~clk;

    lfsr_hex_display u_dut0 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_step_btn   (btn),
        .i_load       (load),
        .i_seed_in    (seed_in[7:0]),
        .o_random     (rand0),
        .o_step_pulse (pulse0),
        .o_seg        (seg0)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .o_period       (period0),
        .o_period_valid (pvalid0)
`endif
    );

    lfsr_hex_display #(
        .WIDTH (10),
        .TAPS  (10'h009),
        .SEED  (10'h3FF)
    ) u_dut1 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_step_btn   (btn),
        .i_load       (load),
        .i_seed_in    (seed_in),
        .o_random     (rand1),
        .o_step_pulse (pulse1),
        .o_seg        (seg1)
`ifdef LFSR_PERIOD_CNT_EN
        ,
        .o_period       (period1),
        .o_period_valid (pvalid1)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic chk_ne(input string name, input int act, input int bad);
        n_total++;
        if (act != bad) n_pass++;
        else $display("FAIL %s: got 0x%0h, required anything but 0x%0h", name, act, bad);
    endtask

    // Model: glyph table, per-instance constants, arithmetic step rule.
    logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int W  [2] = '{8, 10};
    int TP [2] = '{'h1D, 'h009};
    int SD [2] = '{'h01, 'h3FF};
    int DG [2] = '{2, 3};

    function automatic int lfsr_next(input int v, input int w, input int taps);
        int fb;
        fb = $countones(v & taps) & 1;
        return (fb << (w - 1)) | (v >> 1);
    endfunction

    function automatic int seg_of(input int v, input int digits);
        int s;
        s = 0;
        for (int d = 0; d < digits; d++) s |= int'(GLYPH[(v >> (4 * d)) & 15]) << (7 * d);
        return s;
    endfunction

    function automatic int seed_for(input int i);
        return (i == 0) ? int'(seed_in[7:0]) : int'(seed_in);
    endfunction

    int   m_rand  [2];
    int   m_seg   [2];
    logic m_pulse [2];
    logic m_pen, m_pmode, m_pbtn;
    logic m_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_rand[i]  <= SD[i];
                m_pulse[i] <= 1'b0;
                m_seg[i]   <= (1 << (7 * DG[i])) - 1;
            end else begin
                m_seg[i] <= seg_of(m_rand[i], DG[i]);
                if (load) begin
                    m_rand[i]  <= (seed_for(i) == 0) ? 1 : seed_for(i);
                    m_pulse[i] <= 1'b0;
                end else if (m_rand[i] == 0) begin
                    m_rand[i]  <= 1;
                    m_pulse[i] <= 1'b0;
                end else if (m_pen && (!m_pmode || (btn && !m_pbtn))) begin
                    m_rand[i]  <= lfsr_next(m_rand[i], W[i], TP[i]);
                    m_pulse[i] <= 1'b1;
                end else begin
                    m_pulse[i] <= 1'b0;
                end
            end
        end
        if (rst) begin
            m_pen   <= 1'b0;
            m_pmode <= 1'b0;
            m_pbtn  <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_pen   <= en;
            m_pmode <= mode;
            m_pbtn  <= btn;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_rand0", int'(rand0), m_rand[0]);
            chk("cyc_pulse0", int'(pulse0), int'(m_pulse[0]));
            chk("cyc_seg0", int'(seg0), m_seg[0]);
            chk("cyc_rand1", int'(rand1), m_rand[1]);
            chk("cyc_pulse1", int'(pulse1), int'(m_pulse[1]));
            chk("cyc_seg1", int'(seg1), m_seg[1]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    int npulse;
    int exp_seq [5] = '{'h80, 'h40, 'h20, 'h10, 'h88};

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; btn = 1'b0; load = 1'b0; seed_in = '0;
        repeat (3) cyc();
        chk("rst_rand0", rand0, 'h01);
        chk("rst_seg0_blank", seg0, 'h3FFF);
        chk("rst_pulse0", pulse0, 0);
        chk("rst_rand1", rand1, 'h3FF);
        chk("rst_seg1_blank", seg1, 'h1FFFFF);

        // Free-run from reset
        rst = 1'b0;
        cyc();
        chk("t1_first_rand", rand0, 'h01);
        chk("t1_first_pulse", pulse0, 0);
        chk("t1_seg_01", seg0, 14'b1000000_1111001);
        chk("t5_digit2_is_3", seg1[20:14], 7'b0110000);
        foreach (exp_seq[j]) begin
            cyc();
            chk("t1_seq", rand0, exp_seq[j]);
            chk("t1_pulse", pulse0, 1);
        end
        for (int k = 6; k <= 255; k++) begin
            cyc();
            if (k < 255) chk_ne("t2_early_return", rand0, 'h01);
            chk_ne("t2_zero_state", rand0, 0);
        end
        chk("t2_period_255", rand0, 'h01);

        // Single-step with held button
        en = 1'b0; mode = 1'b1;
        cyc();
`ifdef LFSR_PERIOD_CNT_EN
        chk("t2_period_cnt", period0, 255);
        chk("t2_period_valid", pvalid0, 1);
`endif
        load = 1'b1; seed_in = 10'h001;
        cyc();
        load = 1'b0;
        chk("t3_loaded", rand0, 'h01);
        en = 1'b1;
        cyc();
        chk("t3_no_step_on_entry", rand0, 'h01);
        btn = 1'b1; npulse = 0;
        repeat (10) begin cyc(); npulse += int'(pulse0); end
        chk("t3_held_rand", rand0, 'h80);
        chk("t3_held_pulses", npulse, 1);
        btn = 1'b0;
        cyc(); cyc();
        chk("t3_released", rand0, 'h80);
        btn = 1'b1;
        cyc();
        chk("t3_second_press", rand0, 'h40);
        chk("t3_second_pulse", pulse0, 1);

        // Seed load: zero seed and load priority over a running step
        load = 1'b1; seed_in = 10'h000; mode = 1'b0;
        cyc();
        chk("t4_zero_seed", rand0, 'h01);
        chk("t4_zero_seed_pulse", pulse0, 0);
        seed_in = 10'h0A5;
        cyc();
        chk("t4_load_a5", rand0, 'hA5);
        chk("t4_load_pulse", pulse0, 0);
        chk("t4_load_a5_w10", rand1, 'h0A5);
        load = 1'b0; en = 1'b0;
        cyc();
        chk("t4_seg_a5", seg0, 14'b0001000_0010010);

        // 10-bit instance: full period and top-digit range
        rst = 1'b1;
        cyc();
        rst = 1'b0; en = 1'b1; mode = 1'b0; btn = 1'b0;
        for (int k = 1; k <= 1024; k++) begin
            cyc();
            if (k >= 2 && k < 1024) chk_ne("t5_early_return", rand1, 'h3FF);
            chk("t5_digit2_range",
                int'(seg1[20:14] inside {7'h40, 7'h79, 7'h24, 7'h30}), 1);
        end
        chk("t5_period_1023", rand1, 'h3FF);

        // Reset mid-run with a button held through release
        en = 1'b0;
        cyc();
`ifdef LFSR_PERIOD_CNT_EN
        chk("t5_period_cnt", period1, 1023);
        chk("t5_period_valid", pvalid1, 1);
`endif
        rst = 1'b1; mode = 1'b1; btn = 1'b1;
        cyc();
        chk("t6_rst_rand0", rand0, 'h01);
        chk("t6_rst_seg0", seg0, 'h3FFF);
        chk("t6_rst_pulse0", pulse0, 0);
        chk("t6_rst_rand1", rand1, 'h3FF);
        rst = 1'b0; en = 1'b1;
        cyc();
        chk("t6_seg_seed", seg0, 14'b1000000_1111001);
        npulse = 0;
        repeat (5) begin cyc(); npulse += int'(pulse0); end
        chk("t6_held_no_step", rand0, 'h01);
        chk("t6_held_no_pulse", npulse, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lfsr_hex_display.md
Name: lfsr_hex_display

Overview:
Parametrised Fibonacci LFSR pseudo-random generator with a registered multi-digit hex seven-segment driver. It is the next generation of the fixed 8-bit LFSR plus two-digit display block. Width, taps and seed are parameters. It adds a runtime seed load, free-run and single-step modes, all-zero lockup recovery and a step strobe. It sits between board inputs (switches, button) and the seven-segment outputs.

Parameters:
WIDTH, 8, LFSR state width; legal 4..32.
TAPS, 8'h1D, tap mask, WIDTH bits; bit i set means state[i] feeds the XOR; default taps bits 4,3,2,0, maximal period 255.
SEED, 8'h01, reset state, WIDTH bits; must be non-zero.
DIGITS, (WIDTH+3)/4, number of hex digits driven; derived, not overridden.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  run enable; when 0 the state holds
mode  in  1  0 = free-run (one step per cycle while en), 1 = single-step (one step per step_btn rising edge while en)
step_btn  in  1  step request, already synchronised/debounced upstream
load  in  1  load seed_in this cycle
seed_in  in  WIDTH  runtime seed
random  out  WIDTH  current LFSR state
step_pulse  out  1  high for 1 cycle after each advance
seg  out  7*DIGITS  active-low segments {g..a}; seg[7i+6:7i] shows nibble i of random

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and is sampled only on the clk rising edge.
- Reset values:
  - random = SEED; step_pulse = 0.
  - seg = all ones (blank); btn_q = 0; FSM = IDLE.
- Step rule: fb = XOR-reduce(random & TAPS); next = {fb, random[WIDTH-1:1]} (shift right, feedback into MSB).
- FSM states:
  - IDLE: en=0.
  - RUN: en=1, mode=0.
  - SINGLE: en=1, mode=1.
  - Transitions are evaluated each cycle from en/mode; the state register takes the new value the next cycle. The step decision uses the current registered state.
- RUN: random advances every cycle.
- SINGLE: edge detect with btn_q <= step_btn.
  - Advance once when step_btn & ~btn_q.
  - A held button gives exactly one step.
  - btn_q updates in every state, so a press held across entry to SINGLE gives no step.
- IDLE: random holds; the button edge is ignored.
- Priority: rst > load > lockup recovery > step.
  - load=1: random <= (seed_in==0) ? 1 : seed_in. No step that cycle, step_pulse=0.
  - Lockup: if random==0 (only possible via a corrupted state), next random = 1, step_pulse=0.
- step_pulse: registered; 1 in the cycle after an advance was taken.
- seg: registered hex decode of random, latency 1 cycle.
  - Digits 0..F use standard glyphs with lowercase b and d, active-low.
  - The top digit is zero-padded when WIDTH%4 != 0.
  - seg is blank only during reset and for the first cycle after it.
- Reset mid-operation: state, FSM and edge detector return to reset values on the next edge. A button held through reset release gives no step.
- Wrap: no terminal condition. The sequence repeats with period 2^WIDTH-1 for primitive taps.

Optional Feature:
Macro LFSR_PERIOD_CNT_EN.
- Defined:
  - Adds outputs period (32 bits) and period_valid (1 bit).
  - An internal counter increments on each advance and is captured into period when random returns to the last loaded/reset seed.
  - On capture, period_valid is set and sticky, and the counter restarts at 1.
  - load or rst clears the counter, period and period_valid.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset with defaults, en=1, mode=0 -> random sequence 0x01, 0x80, 0x40, 0x20, 0x10, 0x88 on successive cycles; step_pulse high from the second cycle.
2. Free-run 255 cycles from 0x01 -> random back to 0x01, no zero state seen. With LFSR_PERIOD_CNT_EN -> period=255, period_valid=1.
3. mode=1, step_btn held high 10 cycles from 0x01 -> exactly one step to 0x80, one step_pulse. Release and press again -> 0x40.
4. load=1, seed_in=0x00 -> random=0x01. load=1 with en=1 and seed_in=0xA5 -> random=0xA5 with no simultaneous step, step_pulse=0. One cycle later seg = {digit1 "A"=7'b0001000, digit0 "5"=7'b0010010}.
5. WIDTH=10, TAPS=10'h009, SEED=10'h3FF -> DIGITS=3. seg digit2 shows "3" and never exceeds 3. Free-run -> period 1023.
6. rst asserted mid-run with en=0 -> random=SEED, seg blank the next cycle, decoded SEED one cycle after rst deasserts. A step_btn held through reset release gives no step.
